// File: rtl/lut_access_arbiter_if.sv
// lut_access_arbiter_if: Rx lookup read ports plus host write port for the shared LUT.
interface lut_access_arbiter_if #(
  parameter int NUM_RX = 4,
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 16
);
  logic [NUM_RX-1:0]       rd_req;
  logic [NUM_RX*ASIZE-1:0] rd_addr;
  logic [NUM_RX-1:0]       rd_gnt;
  logic [NUM_RX-1:0]       rd_valid;
  logic [DWIDTH-1:0]       rd_data;
  logic                    host_wr_req;
  logic [ASIZE-1:0]        host_addr;
  logic [DWIDTH-1:0]       host_wdata;
  logic                    host_wr_ack;
  logic                    init_done;
  modport master (
    output rd_req, rd_addr, host_wr_req, host_addr, host_wdata,
    input  rd_gnt, rd_valid, rd_data, host_wr_ack, init_done
  );
  modport slave (
    input  rd_req, rd_addr, host_wr_req, host_addr, host_wdata,
    output rd_gnt, rd_valid, rd_data, host_wr_ack, init_done
  );
endinterface

// File: rtl/lut_access_arbiter.sv
// lut_access_arbiter: single-access LUT shared by round-robin readers and a priority host writer.
module lut_access_arbiter #(
  parameter int NUM_RX = 4,
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 16
) (
  input logic clk,
  input logic rst,
  lut_access_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_RX);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state, state_next;
  logic [ASIZE-1:0]  cnt;
  logic [PW-1:0]     p, sel, ci;
  logic              found, run, last;
  logic [DWIDTH-1:0] mem [2**ASIZE];
  // search from the round-robin pointer for the first requesting port
  always_comb begin
    found = 1'b0;
    sel = '0;
    ci = '0;
    for (int k = 0; k < NUM_RX; k++) begin
      ci = PW'((int'(p) + k) % NUM_RX);
      if (!found && bus.rd_req[ci]) begin
        found = 1'b1;
        sel = ci;
      end
    end
  end
  always_comb begin
    run = (state == RUN) && !rst;
    last = (state == INIT) && (cnt == '1);
    state_next = last ? RUN : state;
    bus.host_wr_ack = run && bus.host_wr_req;
    bus.rd_gnt = (run && !bus.host_wr_req && found) ? NUM_RX'(1) << sel : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= '0;
      else if (bus.host_wr_ack) mem[bus.host_addr] <= bus.host_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      p <= '0;
      bus.init_done <= 1'b0;
      bus.rd_valid <= '0;
      bus.rd_data <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (last) bus.init_done <= 1'b1;
      bus.rd_valid <= bus.rd_gnt;
      if (|bus.rd_gnt) begin
        bus.rd_data <= mem[bus.rd_addr[int'(sel)*ASIZE +: ASIZE]];
        p <= (sel == PW'(NUM_RX-1)) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: doc/lut_access_arbiter.md
Name: lut_access_arbiter

Overview:
Owns the cell-rewriting/forwarding lookup table storage and shares it between NUM_RX receive-port lookup requesters and one host/management write port. A single table access is performed per clock. Host writes have priority and reads are granted round-robin. After reset, an init sequencer clears every entry before any access is granted. It sits between the per-port Rx cell processors and the host configuration interface in the ATM forwarding node.

Parameters:
NUM_RX, 4, number of read requesters (Rx ports); legal range 2..16
ASIZE, 8, table address width; depth = 2**ASIZE entries
DWIDTH, 16, table entry width (rewrite VPI + forward mask)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
rd_req  input  NUM_RX  per-port read request; held high with address until granted
rd_addr  input  NUM_RX*ASIZE  packed addresses; port i uses [i*ASIZE +: ASIZE]
rd_gnt  output  NUM_RX  combinational one-hot grant; access performed this cycle
rd_valid  output  NUM_RX  registered one-hot; rd_data valid for that port
rd_data  output  DWIDTH  registered read data, shared by all ports
host_wr_req  input  1  host write request; held with addr/data until acked
host_addr  input  ASIZE  host write address
host_wdata  input  DWIDTH  host write data
host_wr_ack  output  1  combinational; write performed this cycle
init_done  output  1  registered; high once table clear completes

Behaviour:
- Storage: internal array of 2**ASIZE x DWIDTH; single access per cycle (write or read).
- Reset (rst high at edge): state<=INIT, init counter<=0, rr pointer<=0, init_done<=0, rd_valid<=0, rd_data<=0. rd_gnt and host_wr_ack are forced 0 while rst is high or the state is INIT.
- FSM INIT: each cycle Mem[cnt]<=0, cnt<=cnt+1. On the cycle writing entry 2**ASIZE-1, state<=RUN and init_done<=1. INIT lasts exactly 2**ASIZE cycles. No grants or acks are issued; requests stay pending.
- FSM RUN: stays in RUN until rst. Access priority per cycle is as follows.
  1. host_wr_req=1: host_wr_ack=1, Mem[host_addr]<=host_wdata, rd_gnt=0, rr pointer unchanged.
  2. Otherwise, if any rd_req bit is set: grant the first requesting index searching from p, p+1, ... mod NUM_RX. rd_gnt[i]=1, Mem[rd_addr_i] is read, and p<=(i+1) mod NUM_RX.
  3. Otherwise: no access, pointer unchanged.
- Read latency: grant in cycle N gives rd_valid[i]=1 and rd_data=entry in cycle N+1 (one-cycle pulse). When no read is granted, rd_valid=0 next cycle and rd_data holds its previous value.
- Handshake: a requester samples rd_gnt/host_wr_ack at the clock edge. It may keep req asserted for back-to-back accesses with a new address after the grant. The arbiter never grants a port whose req is low.
- Ordering: a host write in cycle N is visible to a read granted in cycle N+1 or later. Same-cycle write/read cannot occur.
- Fairness: any continuously requesting reader is granted within NUM_RX read-grant cycles. Continuous host writes starve readers by design; host software spaces writes.
- Reset mid-operation: the next cycle is INIT, any rd_valid due from the prior cycle is suppressed (0), and the table is fully re-cleared.
- Widths: the init counter is ASIZE+1 bits or equivalent terminal detect. The pointer is clog2(NUM_RX) bits and wraps NUM_RX-1 -> 0.

Test Plan:
1. Reset with ASIZE=8, hold rd_req=0 -> init_done rises exactly 256 cycles after rst drops; then read of addr 0xFF returns rd_data=0x0000.
2. Host write addr 0x12 data 0xBEEF (ack same cycle); next cycle rd_req[2] addr 0x12 -> rd_gnt=0100, following cycle rd_valid=0100, rd_data=0xBEEF.
3. rd_req=1111 held with addrs 0x01..0x04 preloaded 0xA001..0xA004 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; rd_data sequence 0xA001..0xA004,0xA001, each one cycle after its grant.
4. host_wr_req and rd_req[1] asserted in the same cycle (p=1) -> host_wr_ack=1, rd_gnt=0000; next cycle rd_gnt=0010.
5. rd_req=1010 asserted during INIT -> no grants before init_done. First RUN cycle grants port 1 (p=0 search), then port 3.
6. After writing 0x5A=0x1234, assert rst for 1 cycle during an outstanding read -> rd_valid=0 next cycle, init_done=0. After 256 cycles, init_done=1 and read of 0x5A returns 0x0000.
